// File: rtl/inverse_factorial_pkg.sv
// inverse_factorial_pkg
// Shared constants and the FSM state type for the inverse-factorial engine.
// The state encoding matches the forward factorial engine so one controller
// can drive either unit with identical sequencing.
package inverse_factorial_pkg;

    // Largest n whose factorial fits in 32 bits (12! = 479001600).
    localparam int MAX_N  = 12;

    localparam int VAL_W  = 32;
    localparam int N_W    = 4;
    // A 32-bit running factorial times a 4-bit multiplier needs 36 bits, so
    // the compare against the operand never sees a truncated product.
    localparam int PROD_W = 36;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OP   = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/inverse_factorial.sv
// inverse_factorial
// Finds the largest n (1..12) with n! <= value and reports whether n! equals
// value exactly. Iterative: one multiply and one compare per cycle.
//
// Ports:
//   clk    in   1   rising-edge clock
//   rst_n  in   1   asynchronous active-low reset
//   start  in   1   request, sampled only while ready=1
//   value  in  32   unsigned operand, latched on the accepted start
//   ready  out  1   high while idle
//   tick   out  1   one-cycle pulse when n_out/exact are fresh
//   n_out  out  4   result n (0 when value was 0), held until next result
//   exact  out  1   1 when n_out! == latched value, held with n_out
module inverse_factorial
    import inverse_factorial_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [VAL_W-1:0] value,
    output logic             ready,
    output logic             tick,
    output logic [N_W-1:0]   n_out,
    output logic             exact
);

    state_t state;
    state_t state_next;

    logic [VAL_W-1:0]  value_q;
    logic [VAL_W-1:0]  value_next;
    logic [VAL_W-1:0]  fact;
    logic [VAL_W-1:0]  fact_next;
    logic [N_W-1:0]    k;
    logic [N_W-1:0]    k_next;
    logic [N_W-1:0]    k_inc;
    logic [N_W-1:0]    n_next;
    logic              exact_next;
    logic [PROD_W-1:0] prod;
    logic              overshoot;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath update. fact always holds k! while in OP.
    always_comb begin
        state_next = state;
        value_next = value_q;
        fact_next  = fact;
        k_next     = k;
        n_next     = n_out;
        exact_next = exact;

        k_inc     = k + N_W'(1);
        prod      = PROD_W'(fact) * PROD_W'(k_inc);
        // The k==MAX_N term is redundant (13 * 12! already exceeds any
        // 32-bit value) but pins the loop bound independently of the compare.
        overshoot = (prod > {{(PROD_W-VAL_W){1'b0}}, value_q}) ||
                    (k >= N_W'(MAX_N));

        case (state)
            IDLE: begin
                if (start) begin
                    if (value != '0) begin
                        value_next = value;
                        fact_next  = VAL_W'(1);
                        k_next     = N_W'(1);
                        state_next = OP;
                    end else begin
                        // 0! is not reported; zero short-circuits to n=0.
                        n_next     = '0;
                        exact_next = 1'b0;
                        state_next = DONE;
                    end
                end
            end
            OP: begin
                if (overshoot) begin
                    n_next     = k;
                    exact_next = (fact == value_q);
                    state_next = DONE;
                end else begin
                    fact_next = prod[VAL_W-1:0];
                    k_next    = k_inc;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
            fact    <= VAL_W'(1);
            k       <= N_W'(1);
            n_out   <= '0;
            exact   <= 1'b0;
        end else begin
            value_q <= value_next;
            fact    <= fact_next;
            k       <= k_next;
            n_out   <= n_next;
            exact   <= exact_next;
        end
    end

    // Output decode
    assign ready = (state == IDLE);
    assign tick  = (state == DONE);

endmodule

// File: tb/tb_inverse_factorial.sv
module tb_inverse_factorial;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] value;
    logic        ready;
    logic        tick;
    logic [3:0]  n_out;
    logic        exact;

    int checks = 0;
    int errors = 0;

    inverse_factorial dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .value (value),
        .ready (ready),
        .tick  (tick),
        .n_out (n_out),
        .exact (exact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1);
    end

    // Reference: largest n with n! <= v (0 for v==0), plus exactness.
    function automatic void model(input logic [31:0] v, output int n, output logic ex);
        longint f;
        if (v == 32'd0) begin
            n  = 0;
            ex = 1'b0;
        end else begin
            f = 1;
            n = 1;
            while (f * longint'(n + 1) <= longint'(v)) begin
                f = f * longint'(n + 1);
                n = n + 1;
            end
            ex = (f == longint'(v));
        end
    endfunction

    function automatic longint fact_of(input int n);
        longint f = 1;
        for (int i = 2; i <= n; i++) f = f * i;
        return f;
    endfunction

    // Drives one request from idle and observes the response. lat counts
    // negedges after E0 until tick (0 = cycle after E0).
    task automatic run_op(input logic [31:0] v, output int lat, output logic [3:0] n_o,
                          output logic ex_o, output logic rdy_during, output logic rdy_after,
                          output logic tick_after);
        @(negedge clk);
        start = 1'b1;
        value = v;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        value = $urandom;
        lat = 0;
        rdy_during = 1'b0;
        forever begin
            rdy_during = rdy_during | ready;
            if (tick === 1'b1 || lat >= 20) break;
            @(negedge clk);
            lat++;
        end
        n_o  = n_out;
        ex_o = exact;
        @(negedge clk);
        rdy_after  = ready;
        tick_after = tick;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        value = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
        checks++;
        if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b want 0", tick); end
        checks++;
        if (n_out !== 4'd0) begin errors++; $display("FAIL reset_n_out: got %0d want 0", n_out); end
        checks++;
        if (exact !== 1'b0) begin errors++; $display("FAIL reset_exact: got %b want 0", exact); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_op(input string name, input logic [31:0] v);
        int lat, n_exp;
        logic [3:0] n_o;
        logic ex_o, ex_exp, rd, ra, ta;
        model(v, n_exp, ex_exp);
        run_op(v, lat, n_o, ex_o, rd, ra, ta);
        checks++;
        if (lat != n_exp) begin errors++; $display("FAIL %s latency v=%0d: got %0d want %0d", name, v, lat, n_exp); end
        checks++;
        if (n_o !== 4'(n_exp)) begin errors++; $display("FAIL %s n_out v=%0d: got %0d want %0d", name, v, n_o, n_exp); end
        checks++;
        if (ex_o !== ex_exp) begin errors++; $display("FAIL %s exact v=%0d: got %b want %b", name, v, ex_o, ex_exp); end
        checks++;
        if (rd !== 1'b0) begin errors++; $display("FAIL %s ready_busy v=%0d: got %b want 0", name, v, rd); end
        checks++;
        if (ra !== 1'b1 || ta !== 1'b0) begin
            errors++; $display("FAIL %s after_done v=%0d: ready=%b tick=%b want ready=1 tick=0", name, v, ra, ta);
        end
    endtask

    task automatic test_directed();
        check_op("d120", 32'd120);
        check_op("d121", 32'd121);
        check_op("dmax", 32'hFFFF_FFFF);
        check_op("d12f", 32'd479001600);
        check_op("dzero", 32'd0);
        check_op("done", 32'd1);
        check_op("d2", 32'd2);
        // results hold through idle
        repeat (4) @(negedge clk);
        checks++;
        if (n_out !== 4'd2 || exact !== 1'b1 || tick !== 1'b0) begin
            errors++; $display("FAIL hold_idle: n_out=%0d exact=%b tick=%b want 2 1 0", n_out, exact, tick);
        end
    endtask

    task automatic test_random();
        logic [31:0] v;
        int sel, n;
        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0: v = $urandom;
                1: v = $urandom_range(0, 6000);
                2: begin
                    n = $urandom_range(1, 12);
                    v = 32'(fact_of(n));
                end
                default: begin
                    n = $urandom_range(2, 12);
                    v = 32'(fact_of(n)) + 32'($urandom_range(0, 2)) - 32'd1;
                end
            endcase
            check_op("rand", v);
        end
    endtask

    task automatic test_back_to_back();
        int lat, n_exp;
        logic ex_exp;
        // Start held high: a second operation begins on the first ready cycle.
        @(negedge clk);
        start = 1'b1;
        value = 32'd24;
        @(posedge clk);
        @(negedge clk);
        value = 32'd6;
        lat = 0;
        while (tick !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
        checks++;
        if (lat != 4 || n_out !== 4'd4 || exact !== 1'b1) begin
            errors++; $display("FAIL b2b_first: lat=%0d n_out=%0d exact=%b want 4 4 1", lat, n_out, exact);
        end
        @(negedge clk);
        // ready cycle; start still high, sampled at the next edge with value=6
        @(negedge clk);
        start = 1'b0;
        model(32'd6, n_exp, ex_exp);
        lat = 0;
        while (tick !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
        checks++;
        if (lat != n_exp || n_out !== 4'(n_exp) || exact !== ex_exp) begin
            errors++; $display("FAIL b2b_second: lat=%0d n_out=%0d exact=%b want %0d %0d %b", lat, n_out, exact, n_exp, n_exp, ex_exp);
        end
        @(negedge clk);
    endtask

    task automatic test_mid_start();
        int lat;
        @(negedge clk);
        start = 1'b1;
        value = 32'd720;
        @(posedge clk);           // E0
        @(negedge clk);
        start = 1'b0;
        value = 32'd5;
        @(posedge clk);           // E1
        @(negedge clk);
        start = 1'b1;             // sampled at E2 while busy
        @(posedge clk);           // E2
        @(negedge clk);
        start = 1'b0;
        lat = 2;
        while (tick !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
        checks++;
        if (lat != 6) begin errors++; $display("FAIL midstart_latency: got %0d want 6", lat); end
        checks++;
        if (n_out !== 4'd6 || exact !== 1'b1) begin
            errors++; $display("FAIL midstart_result: n_out=%0d exact=%b want 6 1", n_out, exact);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (ready !== 1'b1 || tick !== 1'b0) begin
            errors++; $display("FAIL midstart_not_queued: ready=%b tick=%b want 1 0", ready, tick);
        end
    endtask

    task automatic test_mid_reset();
        int ticks_seen = 0;
        int bad = 0;
        @(negedge clk);
        start = 1'b1;
        value = 32'd5040;
        @(posedge clk);           // E0
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);           // E1
        @(posedge clk);           // E2
        @(posedge clk);           // E3
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b1 || tick !== 1'b0) begin
            errors++; $display("FAIL midreset_ctrl: ready=%b tick=%b want 1 0", ready, tick);
        end
        checks++;
        if (n_out !== 4'd0 || exact !== 1'b0) begin
            errors++; $display("FAIL midreset_result: n_out=%0d exact=%b want 0 0", n_out, exact);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (tick === 1'b1) ticks_seen++;
            if (ready !== 1'b1 || n_out !== 4'd0) bad++;
        end
        checks++;
        if (ticks_seen != 0 || bad != 0) begin
            errors++; $display("FAIL midreset_after: ticks=%0d bad_cycles=%0d want 0 0", ticks_seen, bad);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_mid_start();
        test_mid_reset();
        check_op("post_reset", 32'd5040);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
